// File: rtl/dw_ahb.sv
// rtl/dw_ahb.sv - two-master, two-slave AHB-Lite fabric with arbiter, decoder and default slave
// Ports:
//   hclk, hresetn                      clock, async active-low reset
//   *_m1 / *_m2                        master address/control/write data and bus request
//   hgrant_m1 / hgrant_m2              registered grant, exactly one high
//   hready, hresp, hrdata              response returned to both masters
//   hready_resp_s*, hresp_s*, hrdata_s* slave responses
//   hsel_s1 / hsel_s2                  slave selects decoded from haddr
//   haddr, hburst, hsize, htrans, hwrite, hwdata  shared slave bus
module dw_ahb (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic [31:0] haddr_m1,
  input  logic [31:0] haddr_m2,
  input  logic        hbusreq_m1,
  input  logic        hbusreq_m2,
  input  logic [2:0]  hburst_m1,
  input  logic [2:0]  hburst_m2,
  input  logic [2:0]  hsize_m1,
  input  logic [2:0]  hsize_m2,
  input  logic [1:0]  htrans_m1,
  input  logic [1:0]  htrans_m2,
  input  logic [31:0] hwdata_m1,
  input  logic [31:0] hwdata_m2,
  input  logic        hwrite_m1,
  input  logic        hwrite_m2,
  output logic        hgrant_m1,
  output logic        hgrant_m2,
  output logic        hready,
  output logic [1:0]  hresp,
  output logic [31:0] hrdata,
  input  logic        hready_resp_s1,
  input  logic        hready_resp_s2,
  input  logic [1:0]  hresp_s1,
  input  logic [1:0]  hresp_s2,
  input  logic [31:0] hrdata_s1,
  input  logic [31:0] hrdata_s2,
  output logic        hsel_s1,
  output logic        hsel_s2,
  output logic [31:0] haddr,
  output logic [2:0]  hburst,
  output logic [2:0]  hsize,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [31:0] hwdata
);

  typedef enum logic [1:0] {SEL_NONE, SEL_S1, SEL_S2, SEL_DEF} sel_t;
  typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_t;

  // Master indices: 0 = m1, 1 = m2
  logic      grant;
  logic      addr_owner;
  logic      data_owner;
  sel_t      data_sel;
  sel_t      dec_sel;
  ds_state_t ds_state;
  logic      def_ready;
  logic      def_err;
  logic      active;

  assign hgrant_m1 = ~grant;
  assign hgrant_m2 = grant;

  // Arbiter: current owner keeps the bus while requesting, else m1 has priority,
  // and m1 is the default master when nobody requests.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      grant <= 1'b0;
    end else if (hready) begin
      if (grant && hbusreq_m2)
        grant <= 1'b1;
      else if (hbusreq_m1)
        grant <= 1'b0;
      else if (hbusreq_m2)
        grant <= 1'b1;
      else
        grant <= 1'b0;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      addr_owner <= 1'b0;
      data_owner <= 1'b0;
    end else if (hready) begin
      addr_owner <= grant;
      data_owner <= addr_owner;
    end
  end

  assign haddr  = addr_owner ? haddr_m2  : haddr_m1;
  assign hburst = addr_owner ? hburst_m2 : hburst_m1;
  assign hsize  = addr_owner ? hsize_m2  : hsize_m1;
  assign htrans = addr_owner ? htrans_m2 : htrans_m1;
  assign hwrite = addr_owner ? hwrite_m2 : hwrite_m1;
  assign hwdata = data_owner ? hwdata_m2 : hwdata_m1;

  // Decoder: 64 KiB regions at 0x0000_0000 and 0x0001_0000, everything else unmapped
  always_comb begin
    dec_sel = SEL_DEF;
    if (haddr[31:16] == 16'h0000)
      dec_sel = SEL_S1;
    else if (haddr[31:16] == 16'h0001)
      dec_sel = SEL_S2;
  end

  assign hsel_s1 = (dec_sel == SEL_S1);
  assign hsel_s2 = (dec_sel == SEL_S2);
  assign active  = htrans[1];  // NONSEQ or SEQ

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)
      data_sel <= SEL_NONE;
    else if (hready)
      data_sel <= active ? dec_sel : SEL_NONE;
  end

  // Default slave: two-cycle ERROR. ERR1 stalls the bus, ERR2 completes it;
  // a back-to-back unmapped transfer may restart from ERR2.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ds_state  <= DS_IDLE;
      def_ready <= 1'b1;
      def_err   <= 1'b0;
    end else begin
      case (ds_state)
        DS_ERR1: begin
          ds_state  <= DS_ERR2;
          def_ready <= 1'b1;
          def_err   <= 1'b1;
        end
        default: begin
          if (hready) begin
            if (active && dec_sel == SEL_DEF) begin
              ds_state  <= DS_ERR1;
              def_ready <= 1'b0;
              def_err   <= 1'b1;
            end else begin
              ds_state  <= DS_IDLE;
              def_ready <= 1'b1;
              def_err   <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    hready = 1'b1;
    hresp  = 2'b00;
    hrdata = 32'h0;
    case (data_sel)
      SEL_S1: begin
        hready = hready_resp_s1;
        hresp  = hresp_s1;
        hrdata = hrdata_s1;
      end
      SEL_S2: begin
        hready = hready_resp_s2;
        hresp  = hresp_s2;
        hrdata = hrdata_s2;
      end
      SEL_DEF: begin
        hready = def_ready;
        hresp  = def_err ? 2'b01 : 2'b00;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dw_ahb.sv
// tb/tb_dw_ahb.sv - directed-vector bench for dw_ahb with two small RAM slave models
module tb_dw_ahb;

  logic        hclk;
  logic        hresetn;
  logic [31:0] haddr_m1, haddr_m2;
  logic        hbusreq_m1, hbusreq_m2;
  logic [2:0]  hburst_m1, hburst_m2;
  logic [2:0]  hsize_m1, hsize_m2;
  logic [1:0]  htrans_m1, htrans_m2;
  logic [31:0] hwdata_m1, hwdata_m2;
  logic        hwrite_m1, hwrite_m2;
  logic        hgrant_m1, hgrant_m2;
  logic        hready;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic        hready_resp_s1, hready_resp_s2;
  logic [1:0]  hresp_s1, hresp_s2;
  logic [31:0] hrdata_s1, hrdata_s2;
  logic        hsel_s1, hsel_s2;
  logic [31:0] haddr;
  logic [2:0]  hburst, hsize;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;

  localparam logic [1:0] IDLE = 2'b00, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000, INCR4 = 3'b011;

  int checks = 0;
  int errors = 0;

  dw_ahb dut (
    .hclk(hclk), .hresetn(hresetn),
    .haddr_m1(haddr_m1), .haddr_m2(haddr_m2),
    .hbusreq_m1(hbusreq_m1), .hbusreq_m2(hbusreq_m2),
    .hburst_m1(hburst_m1), .hburst_m2(hburst_m2),
    .hsize_m1(hsize_m1), .hsize_m2(hsize_m2),
    .htrans_m1(htrans_m1), .htrans_m2(htrans_m2),
    .hwdata_m1(hwdata_m1), .hwdata_m2(hwdata_m2),
    .hwrite_m1(hwrite_m1), .hwrite_m2(hwrite_m2),
    .hgrant_m1(hgrant_m1), .hgrant_m2(hgrant_m2),
    .hready(hready), .hresp(hresp), .hrdata(hrdata),
    .hready_resp_s1(hready_resp_s1), .hready_resp_s2(hready_resp_s2),
    .hresp_s1(hresp_s1), .hresp_s2(hresp_s2),
    .hrdata_s1(hrdata_s1), .hrdata_s2(hrdata_s2),
    .hsel_s1(hsel_s1), .hsel_s2(hsel_s2),
    .haddr(haddr), .hburst(hburst), .hsize(hsize),
    .htrans(htrans), .hwrite(hwrite), .hwdata(hwdata)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // RAM slave models: 16 words each, address phase captured, data applied one beat later
  logic [31:0] mem1 [0:15];
  logic [31:0] mem2 [0:15];
  logic        s1_dv, s1_dw, s2_dv, s2_dw;
  logic [3:0]  s1_da, s2_da;
  logic        s1_rdy;

  always @(posedge hclk) begin
    if (!hresetn) begin
      for (int i = 0; i < 16; i++) begin
        mem1[i] <= 32'h0;
        mem2[i] <= 32'h0;
      end
      s1_dv <= 1'b0;
      s2_dv <= 1'b0;
      s1_dw <= 1'b0;
      s2_dw <= 1'b0;
      s1_da <= 4'h0;
      s2_da <= 4'h0;
    end else if (hready) begin
      if (s1_dv && s1_dw) mem1[s1_da] <= hwdata;
      if (s2_dv && s2_dw) mem2[s2_da] <= hwdata;
      s1_dv <= hsel_s1 && htrans[1];
      s2_dv <= hsel_s2 && htrans[1];
      s1_dw <= hwrite;
      s2_dw <= hwrite;
      s1_da <= haddr[5:2];
      s2_da <= haddr[5:2];
    end
  end

  assign hrdata_s1      = (s1_dv && !s1_dw) ? mem1[s1_da] : 32'h0;
  assign hrdata_s2      = (s2_dv && !s2_dw) ? mem2[s2_da] : 32'h0;
  assign hready_resp_s1 = s1_rdy;
  assign hready_resp_s2 = 1'b1;
  assign hresp_s1       = 2'b00;
  assign hresp_s2       = 2'b00;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #2;
  endtask

  task automatic m1(input logic [1:0] t, input logic [31:0] a, input logic w, input logic [2:0] b);
    htrans_m1 = t; haddr_m1 = a; hwrite_m1 = w; hburst_m1 = b;
  endtask

  task automatic m2(input logic [1:0] t, input logic [31:0] a, input logic w, input logic [2:0] b);
    htrans_m2 = t; haddr_m2 = a; hwrite_m2 = w; hburst_m2 = b;
  endtask

  initial begin
    hresetn = 1'b0;
    hbusreq_m1 = 1'b0; hbusreq_m2 = 1'b0;
    hsize_m1 = 3'b010; hsize_m2 = 3'b010;
    hwdata_m1 = 32'h0; hwdata_m2 = 32'h0;
    m1(IDLE, 32'h0, 1'b0, SINGLE);
    m2(IDLE, 32'h0, 1'b0, SINGLE);
    s1_rdy = 1'b1;

    // Reset state
    repeat (2) @(posedge hclk);
    #2;
    check_eq("rst_gnt1", {31'h0, hgrant_m1}, 32'd1);
    check_eq("rst_gnt2", {31'h0, hgrant_m2}, 32'd0);
    check_eq("rst_ready", {31'h0, hready}, 32'd1);
    check_eq("rst_resp", {30'h0, hresp}, 32'd0);
    check_eq("rst_rdata", hrdata, 32'h0);
    hresetn = 1'b1;
    repeat (3) tick();
    check_eq("idle_gnt1", {31'h0, hgrant_m1}, 32'd1);

    // Single write then read to slave 1
    hbusreq_m1 = 1'b1;
    m1(NONSEQ, 32'h0000_0010, 1'b1, SINGLE);
    #1;
    check_eq("wr_hsel", {30'h0, hsel_s1, hsel_s2}, 32'h2);
    check_eq("wr_haddr", haddr, 32'h0000_0010);
    tick();
    hwdata_m1 = 32'hA5A5_5A5A;
    m1(NONSEQ, 32'h0000_0010, 1'b0, SINGLE);
    #1;
    check_eq("wr_hwdata", hwdata, 32'hA5A5_5A5A);
    check_eq("wr_ready", {31'h0, hready}, 32'd1);
    tick();
    m1(IDLE, 32'h0000_0010, 1'b0, SINGLE);
    #1;
    check_eq("rd_data", hrdata, 32'hA5A5_5A5A);
    check_eq("rd_resp", {30'h0, hresp}, 32'd0);

    // INCR4 write burst to slave 2
    for (int i = 0; i < 4; i++) begin
      tick();
      m1((i == 0) ? NONSEQ : SEQ, 32'h0001_0000 + 32'(4 * i), 1'b1, INCR4);
      if (i > 0) hwdata_m1 = 32'h2000_0000 + 32'(i - 1);
      #1;
      check_eq($sformatf("s2_hsel_beat%0d", i), {30'h0, hsel_s1, hsel_s2}, 32'h1);
    end
    tick();
    m1(IDLE, 32'h0001_0010, 1'b0, SINGLE);
    hwdata_m1 = 32'h2000_0003;
    hbusreq_m1 = 1'b0;
    tick();
    #1;
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("s2_mem%0d", i), mem2[i], 32'h2000_0000 + 32'(i));
    check_eq("s1_mem0_untouched", mem1[0], 32'h0);
    check_eq("s1_mem4_kept", mem1[4], 32'hA5A5_5A5A);

    // Arbitration: simultaneous requests, m1 burst, handover to m2
    hbusreq_m1 = 1'b1;
    hbusreq_m2 = 1'b1;
    tick();
    #1;
    check_eq("arb_both_gnt1", {31'h0, hgrant_m1}, 32'd1);
    check_eq("arb_both_gnt2", {31'h0, hgrant_m2}, 32'd0);
    m1(NONSEQ, 32'h0000_0020, 1'b1, INCR4);
    tick();
    hwdata_m1 = 32'h3000_0000;
    m1(SEQ, 32'h0000_0024, 1'b1, INCR4);
    tick();
    hwdata_m1 = 32'h3000_0001;
    m1(SEQ, 32'h0000_0028, 1'b1, INCR4);
    hbusreq_m1 = 1'b0;
    tick();
    hwdata_m1 = 32'h3000_0002;
    m1(SEQ, 32'h0000_002C, 1'b1, INCR4);
    m2(NONSEQ, 32'h0000_0020, 1'b0, SINGLE);
    #1;
    check_eq("hand_gnt2", {31'h0, hgrant_m2}, 32'd1);
    check_eq("hand_m1_last_addr", haddr, 32'h0000_002C);
    tick();
    hwdata_m1 = 32'h3000_0003;
    m1(IDLE, 32'h0000_0044, 1'b0, SINGLE);
    #1;
    check_eq("hand_m2_addr", haddr, 32'h0000_0020);
    check_eq("hand_m2_trans", {30'h0, htrans}, {30'h0, NONSEQ});
    check_eq("hand_m1_last_data", hwdata, 32'h3000_0003);

    // Wait states on m2 read: nothing moves while hready is low
    tick();
    m2(IDLE, 32'h0000_0030, 1'b0, SINGLE);
    hbusreq_m2 = 1'b0;
    hbusreq_m1 = 1'b1;
    s1_rdy = 1'b0;
    #1;
    check_eq("ws1_ready", {31'h0, hready}, 32'd0);
    check_eq("ws1_gnt2", {31'h0, hgrant_m2}, 32'd1);
    check_eq("ws1_haddr", haddr, 32'h0000_0030);
    tick();
    #1;
    check_eq("ws2_ready", {31'h0, hready}, 32'd0);
    check_eq("ws2_gnt1", {31'h0, hgrant_m1}, 32'd0);
    check_eq("ws2_haddr", haddr, 32'h0000_0030);
    tick();
    s1_rdy = 1'b1;
    #1;
    check_eq("ws_done_ready", {31'h0, hready}, 32'd1);
    check_eq("ws_done_rdata", hrdata, 32'h3000_0000);
    check_eq("ws_done_gnt2", {31'h0, hgrant_m2}, 32'd1);
    tick();
    #1;
    check_eq("after_ws_gnt1", {31'h0, hgrant_m1}, 32'd1);

    // Unmapped access from m2
    hbusreq_m1 = 1'b0;
    hbusreq_m2 = 1'b1;
    tick();
    #1;
    check_eq("um_gnt2", {31'h0, hgrant_m2}, 32'd1);
    tick();
    m2(NONSEQ, 32'h8000_0000, 1'b0, SINGLE);
    #1;
    check_eq("um_hsel", {30'h0, hsel_s1, hsel_s2}, 32'h0);
    tick();
    m2(IDLE, 32'h8000_0000, 1'b0, SINGLE);
    #1;
    check_eq("um_c1_ready", {31'h0, hready}, 32'd0);
    check_eq("um_c1_resp", {30'h0, hresp}, 32'd1);
    check_eq("um_c1_rdata", hrdata, 32'h0);
    tick();
    #1;
    check_eq("um_c2_ready", {31'h0, hready}, 32'd1);
    check_eq("um_c2_resp", {30'h0, hresp}, 32'd1);
    tick();
    #1;
    check_eq("um_idle_ready", {31'h0, hready}, 32'd1);
    check_eq("um_idle_resp", {30'h0, hresp}, 32'd0);

    // Reset asserted during an error stall aborts it at once
    m2(NONSEQ, 32'h8000_0004, 1'b0, SINGLE);
    tick();
    #1;
    check_eq("abort_pre_ready", {31'h0, hready}, 32'd0);
    hresetn = 1'b0;
    #1;
    check_eq("abort_ready", {31'h0, hready}, 32'd1);
    check_eq("abort_resp", {30'h0, hresp}, 32'd0);
    check_eq("abort_gnt1", {31'h0, hgrant_m1}, 32'd1);
    check_eq("abort_gnt2", {31'h0, hgrant_m2}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dw_ahb.md
# dw_ahb

Two-master, two-slave AHB-Lite-style bus fabric, sitting between two AHB master interfaces (`AHB_if_a`, `AHB_if_b`) and two AHB RAM slaves (`ahb_ram`).
- Arbitrates bus ownership between the masters.
- Multiplexes the winner's address/control and write data onto a shared slave bus.
- Decodes the address into slave selects.
- Routes the selected slave's response back to both masters.
- Includes a built-in default slave for unmapped addresses.

## Interface
Parameters: none. The address map is fixed; see Operation.

Ports:
- hclk  in  1  bus clock; all state on rising edge
- hresetn  in  1  reset; asynchronous, active-low
- haddr_m1 / haddr_m2  in  32  master address
- hbusreq_m1 / hbusreq_m2  in  1  bus request
- hburst_m1 / hburst_m2  in  3  burst type
- hsize_m1 / hsize_m2  in  3  transfer size
- htrans_m1 / htrans_m2  in  2  transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
- hwdata_m1 / hwdata_m2  in  32  write data
- hwrite_m1 / hwrite_m2  in  1  1 = write
- hgrant_m1 / hgrant_m2  out  1  bus grant
- hready  out  1  transfer-done to both masters
- hresp  out  2  response to both masters (00 OKAY, 01 ERROR)
- hrdata  out  32  read data to both masters
- hready_resp_s1 / hready_resp_s2  in  1  slave ready
- hresp_s1 / hresp_s2  in  2  slave response
- hrdata_s1 / hrdata_s2  in  32  slave read data
- hsel_s1 / hsel_s2  out  1  slave select
- haddr  out  32  shared slave address
- hburst, hsize, htrans, hwrite  out  3/3/2/1  shared slave control
- hwdata  out  32  shared slave write data

## Operation
**Arbiter (registered)**
- Evaluated on every rising hclk where hready=1.
- If the current grantee's hbusreq is high, it keeps the grant.
- Otherwise grant goes to the requesting master with highest priority, m1 over m2.
- If neither master requests, m1 is granted as default master.
- Exactly one hgrant is high at all times.
- Masters hold hbusreq high until their last address beat has been issued; the arbiter never breaks a burst on its own.

**Address phase**
- Register `addr_owner` loads the granted index on each hready=1 edge.
- haddr, hburst, hsize, htrans and hwrite are combinationally muxed from `addr_owner`.

**Data phase**
- Register `data_owner` loads `addr_owner` on each hready=1 edge.
- hwdata is muxed from `data_owner`.

**Decoder (combinational, on shared haddr)**
- 0x0000_0000–0x0000_FFFF: hsel_s1=1.
- 0x0001_0000–0x0001_FFFF: hsel_s2=1.
- Any other address selects the internal default slave; both hsel outputs are 0.
- hsel is driven regardless of htrans; slaves qualify with htrans.

**Response mux**
- Register `data_sel` (s1, s2, default or none) loads the decoded target on each hready=1 edge.
- A target is loaded only if htrans is NONSEQ or SEQ; otherwise `data_sel` loads "none".
- s1/s2 selected: hready, hresp and hrdata are taken from that slave.
- "none": hready=1, hresp=OKAY, hrdata=0.

**Default slave**
- NONSEQ/SEQ to an unmapped address produces a two-cycle ERROR response.
- Cycle 1: hready=0, hresp=01.
- Cycle 2: hready=1, hresp=01.
- hrdata=0 throughout.
- Unmapped IDLE/BUSY transfers get a zero-wait OKAY.

**Reset (hresetn=0, asynchronous)**
- Grant: hgrant_m1=1, hgrant_m2=0.
- Owners: `addr_owner`=`data_owner`=m1.
- Response path: `data_sel`=none, default-slave FSM idle.
- Resulting outputs: hready=1, hresp=00, hrdata=0.
- Reset asserted mid-transfer aborts it immediately; no response is completed.

## Timing
- Request to grant: grant updates at the first hready=1 edge after hbusreq rises, i.e. 1 cycle when the bus is idle.
- Grant to address: a master granted at edge N owns haddr from edge N+1 (hgrant and hready both sampled high at edge N).
- Address to data: the data phase follows its address phase by one cycle, extended while hready=0.
- While hready=0, all of the following freeze: grant, `addr_owner`, `data_owner`, `data_sel`.
- Combinational paths (no added latency):
  - master → slave mux;
  - slave response → master mux;
  - haddr → hsel.
- Simultaneous requests: m1 wins unless m2 already owns the bus with hbusreq held.
- On handover, the old owner's last data phase completes while the new owner drives its first address.

## Test plan
- **Reset:** hresetn=0 → hgrant_m1=1, hgrant_m2=0, hready=1, hresp=00, hrdata=0; release, no requests → grant stays m1.
- **Single write/read:** m1 writes 0xA5A5_5A5A to 0x0000_0010 (NONSEQ), then reads it → hsel_s1=1 in the address phase; hwdata=0xA5A5_5A5A in the data phase; read returns 0xA5A5_5A5A with hresp=OKAY.
- **Slave 2 decode:** m1 INCR4 write burst at 0x0001_0000 (word) → hsel_s2=1, hsel_s1=0 for all 4 beats; s1 RAM unchanged.
- **Arbitration:**
  - both masters raise hbusreq in the same cycle → m1 granted;
  - m1 drops hbusreq after its burst → hgrant_m2=1 at the next hready=1 edge;
  - m2's address appears one cycle later, while m1's last data beat completes.
- **Wait states:** s1 holds hready_resp_s1=0 for 2 cycles during m2 read → hready=0 for 2 cycles; grant and owners do not change even if m1 requests.
- **Unmapped:** m2 NONSEQ read at 0x8000_0000 → hsel_s1=hsel_s2=0; next cycle hready=0/hresp=01, then hready=1/hresp=01; following IDLE gets hresp=00.
